// File: rtl/riscv_rf_pkg.sv
// Shared integer register-file types for decode, writeback arbiter and regfile_mp_sb.
package riscv_rf_pkg;
  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_XLEN-1:0] rf_data_t;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/scoreboard bus of regfile_mp_sb; slave = register file, master = core side.
interface regfile_mp_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]   i_rs;
  logic [NUM_RD*XLEN-1:0] o_rs_dout;
  logic [NUM_RD-1:0]      o_rs_busy;
  logic [NUM_WR-1:0]      i_wr_en;
  logic [NUM_WR*AW-1:0]   i_wr_rd;
  logic [NUM_WR*XLEN-1:0] i_wr_din;
  logic [NUM_WR-1:0]      i_wr_clr;
  logic                   i_sb_set;
  logic [AW-1:0]          i_sb_rd;
  logic                   i_sb_flush;
  logic                   o_busy_any;

  modport slave (
    input  i_rs, i_wr_en, i_wr_rd, i_wr_din, i_wr_clr, i_sb_set, i_sb_rd, i_sb_flush,
    output o_rs_dout, o_rs_busy, o_busy_any
  );

  modport master (
    output i_rs, i_wr_en, i_wr_rd, i_wr_din, i_wr_clr, i_sb_set, i_sb_rd, i_sb_flush,
    input  o_rs_dout, o_rs_busy, o_busy_any
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// rf_scoreboard: per-register busy flops with flush > set > clear priority; entry 0 never busy.
module rf_scoreboard #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sb_set,
  input  logic [AW-1:0]        i_sb_rd,
  input  logic                 i_sb_flush,
  input  logic [NUM_WR-1:0]    i_wr_en,
  input  logic [NUM_WR-1:0]    i_wr_clr,
  input  logic [NUM_WR*AW-1:0] i_wr_rd,
  output logic [DEPTH-1:0]     o_busy,
  output logic                 o_busy_any
);
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_nxt;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_sb_set) w_set[i_sb_rd] = 1'b1;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w] && i_wr_clr[w]) w_clr[i_wr_rd[w*AW +: AW]] = 1'b1;
    end
    // a new producer's set overrides the clear from an older one in the same cycle
    w_nxt    = i_sb_flush ? '0 : (w_set | (r_busy & ~w_clr));
    w_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= w_nxt;
  end

  assign o_busy     = r_busy;
  assign o_busy_any = |r_busy;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy scoreboard; define RF_BYPASS_EN for write-through reads.
module regfile_mp_sb
  import riscv_rf_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  regfile_mp_sb_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0]        r_regs [DEPTH];
  logic [AW-1:0]          w_rs     [NUM_RD];
  logic [AW-1:0]          w_wr_rd  [NUM_WR];
  logic [XLEN-1:0]        w_wr_din [NUM_WR];
  logic [DEPTH-1:0]       w_busy;
  logic [NUM_RD*XLEN-1:0] w_rs_dout;
  logic [NUM_RD-1:0]      w_rs_busy;

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) w_rs[r] = bus.i_rs[r*AW +: AW];
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      w_wr_rd[w]  = bus.i_wr_rd[w*AW +: AW];
      w_wr_din[w] = bus.i_wr_din[w*XLEN +: XLEN];
    end
  end

  // ascending port order makes the highest-index port win on a same-rd collision
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.i_wr_en[w] && (w_wr_rd[w] != '0)) r_regs[w_wr_rd[w]] <= w_wr_din[w];
      end
    end
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sb_set   (bus.i_sb_set),
    .i_sb_rd    (bus.i_sb_rd),
    .i_sb_flush (bus.i_sb_flush),
    .i_wr_en    (bus.i_wr_en),
    .i_wr_clr   (bus.i_wr_clr),
    .i_wr_rd    (bus.i_wr_rd),
    .o_busy     (w_busy),
    .o_busy_any (bus.o_busy_any)
  );

`ifdef RF_BYPASS_EN
  logic [NUM_RD-1:0] w_clr_hit;
  logic [NUM_RD-1:0] w_set_hit;

  always_comb begin
    w_rs_dout = '0;
    w_rs_busy = '0;
    w_clr_hit = '0;
    w_set_hit = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      if (w_rs[r] != '0) begin
        w_rs_dout[r*XLEN +: XLEN] = r_regs[w_rs[r]];
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (bus.i_wr_en[w] && (w_wr_rd[w] == w_rs[r])) begin
            w_rs_dout[r*XLEN +: XLEN] = w_wr_din[w];
            if (bus.i_wr_clr[w]) w_clr_hit[r] = 1'b1;
          end
        end
      end
      w_set_hit[r] = bus.i_sb_set && (bus.i_sb_rd == w_rs[r]);
      w_rs_busy[r] = w_busy[w_rs[r]] && !(w_clr_hit[r] && !w_set_hit[r]);
    end
  end
`else
  always_comb begin
    w_rs_dout = '0;
    w_rs_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      if (w_rs[r] != '0) w_rs_dout[r*XLEN +: XLEN] = r_regs[w_rs[r]];
      w_rs_busy[r] = w_busy[w_rs[r]];
    end
  end
`endif

  assign bus.o_rs_dout = w_rs_dout;
  assign bus.o_rs_busy = w_rs_busy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: directed scenarios then random traffic vs an array model.
module tb_regfile_mp_sb;
  localparam int unsigned XLEN = 32, DEPTH = 32, NUM_RD = 2, NUM_WR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_mp_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [63:0] dout;
    logic [1:0]  rbusy;
    logic        any;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  bit [31:0] mem [32];
  bit        bsy [32];

  logic [4:0]  t_rs [2];
  logic [4:0]  t_wd [2];
  logic [31:0] t_din [2];
  bit          t_we [2];
  bit          t_clr [2];
  bit          t_set, t_flush;
  logic [4:0]  t_sr;

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      t_rs[i] = '0; t_wd[i] = '0; t_din[i] = '0; t_we[i] = 0; t_clr[i] = 0;
    end
    t_set = 0; t_flush = 0; t_sr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0; bsy[i] = 0;
    end
  endtask

  // called aligned to a falling edge; returns at the next falling edge
  task automatic step(input string tag);
    exp_t       e;
    bit [31:0]  d;
    bit         b, ch, any;
    bit         nb [32];
    bus.i_rs       = {t_rs[1], t_rs[0]};
    bus.i_wr_en    = {t_we[1], t_we[0]};
    bus.i_wr_rd    = {t_wd[1], t_wd[0]};
    bus.i_wr_din   = {t_din[1], t_din[0]};
    bus.i_wr_clr   = {t_clr[1], t_clr[0]};
    bus.i_sb_set   = t_set;
    bus.i_sb_rd    = t_sr;
    bus.i_sb_flush = t_flush;
    if (!rst_n) model_reset();
    any = 0;
    for (int i = 0; i < 32; i++) any |= bsy[i];
    e.tag = tag;
    e.any = any;
    e.dout = '0;
    e.rbusy = '0;
    for (int r = 0; r < 2; r++) begin
      d = (t_rs[r] == 0) ? 32'd0 : mem[t_rs[r]];
      b = bsy[t_rs[r]];
`ifdef RF_BYPASS_EN
      ch = 0;
      for (int w = 0; w < 2; w++) begin
        if (t_we[w] && t_wd[w] == t_rs[r] && t_rs[r] != 0) d = t_din[w];
        if (t_we[w] && t_clr[w] && t_wd[w] == t_rs[r]) ch = 1;
      end
      if (ch && !(t_set && t_sr == t_rs[r])) b = 0;
`else
      ch = 0;
`endif
      e.dout[r*32 +: 32] = d;
      e.rbusy[r] = b;
    end
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 32; i++) begin
        nb[i] = bsy[i];
        for (int w = 0; w < 2; w++) if (t_we[w] && t_clr[w] && t_wd[w] == i) nb[i] = 0;
        if (t_set && t_sr == i) nb[i] = 1;
        if (t_flush || i == 0) nb[i] = 0;
      end
      for (int i = 0; i < 32; i++) bsy[i] = nb[i];
      for (int w = 0; w < 2; w++) if (t_we[w] && t_wd[w] != 0) mem[t_wd[w]] = t_din[w];
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.o_rs_dout !== e.dout) begin
          n_bad++;
          $display("FAIL %s rs_dout got %h want %h", e.tag, bus.o_rs_dout, e.dout);
        end
        n_cmp++;
        if (bus.o_rs_busy !== e.rbusy) begin
          n_bad++;
          $display("FAIL %s rs_busy got %b want %b", e.tag, bus.o_rs_busy, e.rbusy);
        end
        n_cmp++;
        if (bus.o_busy_any !== e.any) begin
          n_bad++;
          $display("FAIL %s busy_any got %b want %b", e.tag, bus.o_busy_any, e.any);
        end
      end
    end
  end

  initial begin : stim
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step("reset");
    rst_n = 1'b1;
    step("release");

    // x0 is hard-wired: write and busy-set both ignored
    idle(); t_we[0] = 1; t_wd[0] = 5'd0; t_din[0] = 32'h1234; t_set = 1; t_sr = 5'd0;
    step("x0_wr");
    idle(); step("x0_rd");

    // same-rd collision: port 1 wins
    idle(); t_we[0] = 1; t_wd[0] = 5'd7; t_din[0] = 32'hAAAA;
    t_we[1] = 1; t_wd[1] = 5'd7; t_din[1] = 32'h5555; t_rs[0] = 5'd7;
    step("coll_wr");
    idle(); t_rs[0] = 5'd7; t_rs[1] = 5'd7; step("coll_rd");

    // set x9, then write+clr with same-cycle set, then clr-only
    idle(); t_set = 1; t_sr = 5'd9; t_rs[0] = 5'd9; step("sb_set9");
    idle(); t_rs[0] = 5'd9; step("sb_busy9");
    idle(); t_we[0] = 1; t_wd[0] = 5'd9; t_din[0] = 32'h42; t_clr[0] = 1;
    t_set = 1; t_sr = 5'd9; t_rs[0] = 5'd9; step("sb_setclr9");
    idle(); t_rs[0] = 5'd9; step("sb_still9");
    idle(); t_we[1] = 1; t_wd[1] = 5'd9; t_din[1] = 32'h43; t_clr[1] = 1; t_rs[1] = 5'd9;
    step("sb_clr9");
    idle(); t_rs[0] = 5'd9; step("sb_idle9");

    // flush beats a same-cycle set
    idle(); t_set = 1; t_sr = 5'd3; step("set3");
    idle(); t_set = 1; t_sr = 5'd4; step("set4");
    idle(); t_set = 1; t_sr = 5'd31; t_rs[0] = 5'd3; step("set31");
    idle(); t_flush = 1; t_set = 1; t_sr = 5'd6; t_rs[0] = 5'd31; t_rs[1] = 5'd4;
    step("flush");
    idle(); t_rs[0] = 5'd6; t_rs[1] = 5'd31; step("post_flush");

    // read of a busy register during its clearing write
    idle(); t_set = 1; t_sr = 5'd12; step("set12");
    idle(); t_we[0] = 1; t_wd[0] = 5'd12; t_din[0] = 32'h99; t_clr[0] = 1; t_rs[0] = 5'd12;
    step("byp12");
    idle(); t_rs[0] = 5'd12; step("after12");

    // asynchronous reset mid-cycle, visible before any edge
    idle(); t_we[0] = 1; t_wd[0] = 5'd5; t_din[0] = 32'hDEADBEEF; step("wr5");
    idle(); t_set = 1; t_sr = 5'd9; t_rs[0] = 5'd5; step("rd5");
    idle(); t_rs[0] = 5'd5; step("rd5b");
    rst_n = 1'b0;
    idle(); t_rs[0] = 5'd5; t_rs[1] = 5'd9; step("async_rst");
    rst_n = 1'b1;
    idle(); t_rs[0] = 5'd5; step("rst_release");

    for (int n = 0; n < 400; n++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        t_rs[i]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        t_we[i]  = $urandom_range(0, 1) == 1;
        t_wd[i]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        t_din[i] = $urandom;
        t_clr[i] = $urandom_range(0, 1) == 1;
      end
      t_set   = $urandom_range(0, 2) == 0;
      t_sr    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      t_flush = $urandom_range(0, 19) == 0;
      step("rand");
    end

    idle();
    step("tail");
    repeat (3) @(negedge clk);
    done = 1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
